// File: rtl/clock_disp_pkg.sv
// Shared types and segment constants for the mm:ss 7-segment display stage.
package clock_disp_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_e;

    // Segment bit order is {g,f,e,d,c,b,a}, active-high before any polarity flip.
    localparam seg_t SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_DASH  = 7'h40;

    function automatic seg_t digitSeg(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_DASH;
        end
        return SEG_DIGIT[d];
    endfunction

endpackage

// File: rtl/clock_display_mux_bin2bcd60.sv
// Binary 0-59 to two BCD digits using a compare chain instead of a divider.
module bin2bcd60 (
    input  logic [5:0] value_i,
    output logic [2:0] tens_o,
    output logic [3:0] ones_o,
    output logic       valid_o
);

    logic [5:0] rem;

    // Values 60-63 still decode (tens=5) but are flagged invalid for the caller.
    always_comb begin
        tens_o = 3'd0;
        rem    = value_i;
        if (value_i >= 6'd50) begin
            tens_o = 3'd5;
            rem    = value_i - 6'd50;
        end else if (value_i >= 6'd40) begin
            tens_o = 3'd4;
            rem    = value_i - 6'd40;
        end else if (value_i >= 6'd30) begin
            tens_o = 3'd3;
            rem    = value_i - 6'd30;
        end else if (value_i >= 6'd20) begin
            tens_o = 3'd2;
            rem    = value_i - 6'd20;
        end else if (value_i >= 6'd10) begin
            tens_o = 3'd1;
            rem    = value_i - 6'd10;
        end
        ones_o  = rem[3:0];
        valid_o = (value_i <= 6'd59);
    end

endmodule

// File: rtl/clock_display_mux.sv
// Four-digit mm:ss scanner: frame-coherent snapshot, BCD decode, registered outputs.
module clock_display_mux
    import clock_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 4,
    parameter bit ACTIVE_LOW  = 1'b0,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [3:0]    AN_POL  = {4{ACTIVE_LOW}};
    localparam seg_t          SEG_POL = {7{ACTIVE_LOW}};

    logic [CW-1:0] refreshCnt_q, refreshCnt_d;
    digit_e        digitIdx_q, digitIdx_d;
    logic [5:0]    snapSec_q, snapSec_d;
    logic [5:0]    snapMin_q, snapMin_d;
    logic          loadPending_q, loadPending_d;
    logic [3:0]    an_q, an_d;
    seg_t          seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [2:0] secTens, minTens;
    logic [3:0] secOnes, minOnes;
    logic       secValid, minValid;
    logic [3:0] anRaw;
    seg_t       segRaw;
    logic       dpRaw;

    bin2bcd60 uSecBcd (.value_i(snapSec_q), .tens_o(secTens), .ones_o(secOnes), .valid_o(secValid));
    bin2bcd60 uMinBcd (.value_i(snapMin_q), .tens_o(minTens), .ones_o(minOnes), .valid_o(minValid));

    // The post-reset load edge does not advance the scan, so every digit gets a full slot.
    always_comb begin
        refreshCnt_d  = refreshCnt_q;
        digitIdx_d    = digitIdx_q;
        snapSec_d     = snapSec_q;
        snapMin_d     = snapMin_q;
        loadPending_d = 1'b0;
        if (loadPending_q) begin
            snapSec_d = seconds;
            snapMin_d = minutes;
        end else if (refreshCnt_q == CNT_MAX) begin
            refreshCnt_d = '0;
            digitIdx_d   = digit_e'(digitIdx_q + 2'd1);
            if (digitIdx_q == DIG_MIN_TENS) begin
                snapSec_d = seconds;
                snapMin_d = minutes;
            end
        end else begin
            refreshCnt_d = refreshCnt_q + 1'b1;
        end
    end

    always_comb begin
        segRaw = SEG_BLANK;
        case (digitIdx_q)
            DIG_SEC_ONES: segRaw = secValid ? digitSeg(secOnes) : SEG_DASH;
            DIG_SEC_TENS: segRaw = secValid ? digitSeg({1'b0, secTens}) : SEG_DASH;
            DIG_MIN_ONES: segRaw = minValid ? digitSeg(minOnes) : SEG_DASH;
            DIG_MIN_TENS: begin
                if (!minValid) begin
                    segRaw = SEG_DASH;
                end else if (BLANK_LEAD && (minTens == 3'd0)) begin
                    segRaw = SEG_BLANK;
                end else begin
                    segRaw = digitSeg({1'b0, minTens});
                end
            end
            default: segRaw = SEG_BLANK;
        endcase
        anRaw = 4'b0001 << digitIdx_q;
        dpRaw = (digitIdx_q == DIG_MIN_ONES) && !snapSec_q[0];
        if (loadPending_q) begin
            anRaw  = 4'b0000;
            segRaw = SEG_BLANK;
            dpRaw  = 1'b0;
        end
        an_d  = anRaw ^ AN_POL;
        seg_d = segRaw ^ SEG_POL;
        dp_d  = dpRaw ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refreshCnt_q  <= '0;
            digitIdx_q    <= DIG_SEC_ONES;
            snapSec_q     <= 6'd0;
            snapMin_q     <= 6'd0;
            loadPending_q <= 1'b1;
            an_q          <= AN_POL;
            seg_q         <= SEG_POL;
            dp_q          <= ACTIVE_LOW;
        end else begin
            refreshCnt_q  <= refreshCnt_d;
            digitIdx_q    <= digitIdx_d;
            snapSec_q     <= snapSec_d;
            snapMin_q     <= snapMin_d;
            loadPending_q <= loadPending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_mux.sv
// Scoreboard bench for clock_display_mux: three parameter variants share one stimulus stream.
module tb_clock_display_mux;

    logic       clk;
    logic       rst;
    logic [5:0] secondsIn;
    logic [5:0] minutesIn;
    logic [3:0] an0, anNb, anAl;
    logic [6:0] seg0, segNb, segAl;
    logic       dp0, dpNb, dpAl;

    int edgeCnt = 0;
    int total   = 0;
    int bad     = 0;

    typedef struct {
        int         edgeNo;
        int         inst;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } exp_t;

    exp_t sbq[$];

    clock_display_mux #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LEAD(1'b1)) u0 (
        .clk(clk), .rst(rst), .seconds(secondsIn), .minutes(minutesIn),
        .an(an0), .seg(seg0), .dp(dp0));

    clock_display_mux #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LEAD(1'b0)) uNb (
        .clk(clk), .rst(rst), .seconds(secondsIn), .minutes(minutesIn),
        .an(anNb), .seg(segNb), .dp(dpNb));

    clock_display_mux #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LEAD(1'b1)) uAl (
        .clk(clk), .rst(rst), .seconds(secondsIn), .minutes(minutesIn),
        .an(anAl), .seg(segAl), .dp(dpAl));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic pushExp(input int e, input int inst, input logic [3:0] a,
                           input logic [6:0] s, input logic d, input string name);
        exp_t x;
        x.edgeNo = e;
        x.inst   = inst;
        x.an     = a;
        x.seg    = s;
        x.dp     = d;
        x.name   = name;
        sbq.push_back(x);
    endtask

    task automatic applyStimulus(input logic [5:0] m, input logic [5:0] s);
        minutesIn = m;
        secondsIn = s;
    endtask

    task automatic checkOutput(input exp_t x);
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        case (x.inst)
            1:       begin a = anNb; s = segNb; d = dpNb; end
            2:       begin a = anAl; s = segAl; d = dpAl; end
            default: begin a = an0;  s = seg0;  d = dp0;  end
        endcase
        total++;
        if (x.edgeNo != edgeCnt) begin
            bad++;
            $display("[TB] FAIL %s: checked at edge %0d, required edge %0d", x.name, edgeCnt, x.edgeNo);
        end else if (a !== x.an || s !== x.seg || d !== x.dp) begin
            bad++;
            $display("[TB] FAIL %s: actual an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                     x.name, a, s, d, x.an, x.seg, x.dp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the register updates.
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].edgeNo <= edgeCnt) begin
                checkOutput(sbq.pop_front());
            end
        end
    end

    // Holds reset through the next rising edge (scenario edge 0) and returns its edge number.
    task automatic startScenario(input logic [5:0] m, input logic [5:0] s, output int b);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(m, s);
        b = edgeCnt + 1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [6:0] s1Seg [0:3];
    int b;

    initial begin
        s1Seg[0] = 7'h66;
        s1Seg[1] = 7'h4F;
        s1Seg[2] = 7'h5B;
        s1Seg[3] = 7'h06;
        rst = 1'b1;
        applyStimulus(6'd0, 6'd0);
        repeat (3) @(negedge clk);

        // Scan/decode of 12:34, polarity variant, then seconds change mid-frame.
        startScenario(6'd12, 6'd34, b);
        pushExp(b, 0, 4'b0000, 7'h00, 1'b0, "reset_state");
        pushExp(b, 2, 4'b1111, 7'h7F, 1'b1, "reset_state_al");
        pushExp(b + 1, 0, 4'b0000, 7'h00, 1'b0, "load_edge_inactive");
        for (int k = 2; k < 18; k++) begin
            pushExp(b + k, 0, 4'b0001 << ((k - 2) / 4), s1Seg[(k - 2) / 4],
                    ((k - 2) / 4) == 2, $sformatf("scan_edge%0d", k));
            if (k == 2) pushExp(b + k, 2, 4'b1110, 7'h19, 1'b1, "al_digit0");
        end
        pushExp(b + 18, 0, 4'b0001, 7'h6D, 1'b0, "frame2_digit0");
        pushExp(b + 22, 0, 4'b0010, 7'h4F, 1'b0, "frame2_digit1");
        pushExp(b + 26, 0, 4'b0100, 7'h5B, 1'b0, "frame2_digit2_dp");
        releaseReset();
        repeat (7) @(negedge clk);
        applyStimulus(6'd12, 6'd35);
        repeat (22) @(negedge clk);

        // Leading-zero blanking, with and without BLANK_LEAD.
        startScenario(6'd5, 6'd0, b);
        pushExp(b + 2, 0, 4'b0001, 7'h3F, 1'b0, "blank_sec_ones");
        pushExp(b + 6, 0, 4'b0010, 7'h3F, 1'b0, "blank_sec_tens");
        pushExp(b + 10, 0, 4'b0100, 7'h6D, 1'b1, "blank_min_ones");
        pushExp(b + 14, 0, 4'b1000, 7'h00, 1'b0, "blank_min_tens");
        pushExp(b + 14, 1, 4'b1000, 7'h3F, 1'b0, "noblank_min_tens");
        pushExp(b + 17, 0, 4'b1000, 7'h00, 1'b0, "blank_min_tens_end");
        releaseReset();
        repeat (19) @(negedge clk);

        // Out-of-range minutes show dashes, seconds unaffected.
        startScenario(6'd60, 6'd7, b);
        pushExp(b + 2, 0, 4'b0001, 7'h07, 1'b0, "oor_sec_ones");
        pushExp(b + 6, 0, 4'b0010, 7'h3F, 1'b0, "oor_sec_tens");
        pushExp(b + 10, 0, 4'b0100, 7'h40, 1'b0, "oor_min_ones");
        pushExp(b + 14, 0, 4'b1000, 7'h40, 1'b0, "oor_min_tens");
        pushExp(b + 14, 1, 4'b1000, 7'h40, 1'b0, "oor_min_tens_nb");
        releaseReset();
        repeat (17) @(negedge clk);

        // Reset asserted while digit 2 is displayed; new snapshot 01:09 afterwards.
        startScenario(6'd12, 6'd34, b);
        pushExp(b + 10, 0, 4'b0100, 7'h5B, 1'b1, "pre_midreset_digit2");
        pushExp(b + 12, 0, 4'b0000, 7'h00, 1'b0, "midreset_inactive");
        pushExp(b + 12, 2, 4'b1111, 7'h7F, 1'b1, "midreset_inactive_al");
        pushExp(b + 13, 0, 4'b0000, 7'h00, 1'b0, "midreset_load_edge");
        pushExp(b + 14, 0, 4'b0001, 7'h6F, 1'b0, "midreset_digit0");
        pushExp(b + 18, 0, 4'b0010, 7'h3F, 1'b0, "midreset_digit1");
        pushExp(b + 22, 0, 4'b0100, 7'h06, 1'b0, "midreset_digit2_odd");
        pushExp(b + 26, 0, 4'b1000, 7'h00, 1'b0, "midreset_digit3_blank");
        releaseReset();
        repeat (11) @(negedge clk);
        rst = 1'b1;
        applyStimulus(6'd1, 6'd9);
        @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);

        repeat (3) @(negedge clk);
        while (sbq.size() > 0) begin
            exp_t x;
            x = sbq.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s: never checked, required edge %0d, run ended at edge %0d",
                     x.name, x.edgeNo, edgeCnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
